// File: rtl/uart_rx_cmd_ctrl_if.sv
// Bus bundle between the command sequencer (master side) and the surrounding
// UART RX/TX, register file and ALU (slave side).
interface uart_rx_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]   RX_P_DATA;
    logic                    RX_D_VLD;
    logic                    RX_ERR;
    logic [DATA_WIDTH-1:0]   RdData;
    logic                    RdData_Valid;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    ALU_OUT_VLD;
    logic                    TX_BUSY;
    logic                    WrEn;
    logic                    RdEn;
    logic [ADDR_WIDTH-1:0]   Address;
    logic [DATA_WIDTH-1:0]   WrData;
    logic                    ALU_EN;
    logic [3:0]              ALU_FUN;
    logic                    CLK_GATE_EN;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;
    logic                    cmd_err;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RX_ERR, RdData, RdData_Valid,
               ALU_OUT, ALU_OUT_VLD, TX_BUSY,
        output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
               TX_P_DATA, TX_D_VLD, cmd_err
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RX_ERR, RdData, RdData_Valid,
               ALU_OUT, ALU_OUT_VLD, TX_BUSY,
        input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
               TX_P_DATA, TX_D_VLD, cmd_err
    );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// Command sequencer: parses byte-framed commands from the UART RX stream, drives
// the register file and ALU, and returns results byte by byte to the UART TX.
module uart_rx_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    uart_rx_cmd_ctrl_if.master bus
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
        S_ALU_A, S_ALU_B, S_ALU_FUN, S_ALU_WAIT,
        S_TX_SEND, S_TX_WAIT_BUSY, S_TX_WAIT_IDLE
    } state_t;

    state_t                  r_state, w_next;
    logic                    r_wr_en, w_wr_en;
    logic                    r_rd_en, w_rd_en;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr;
    logic [DATA_WIDTH-1:0]   r_wdata, w_wdata;
    logic                    r_alu_en, w_alu_en;
    logic [3:0]              r_fun, w_fun;
    logic                    r_gate, w_gate;
    logic [DATA_WIDTH-1:0]   r_tx_data, w_tx_data;
    logic                    r_tx_vld, w_tx_vld;
    logic                    r_err, w_err;
    logic [2*DATA_WIDTH-1:0] r_buf, w_buf;
    logic [1:0]              r_cnt, w_cnt;
    logic                    w_accepting;
    logic                    w_rx_ok;
    logic [DATA_WIDTH-1:0]   w_rx_byte;

    assign w_accepting = (r_state inside {S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR,
                                          S_ALU_A, S_ALU_B, S_ALU_FUN});
    assign w_rx_ok     = bus.RX_D_VLD && !bus.RX_ERR && w_accepting;
    assign w_rx_byte   = bus.RX_P_DATA;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_alu_en  <= 1'b0;
            r_fun     <= '0;
            r_gate    <= 1'b0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
            r_err     <= 1'b0;
            r_buf     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next;
            r_wr_en   <= w_wr_en;
            r_rd_en   <= w_rd_en;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_alu_en  <= w_alu_en;
            r_fun     <= w_fun;
            r_gate    <= w_gate;
            r_tx_data <= w_tx_data;
            r_tx_vld  <= w_tx_vld;
            r_err     <= w_err;
            r_buf     <= w_buf;
            r_cnt     <= w_cnt;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_wr_en   = 1'b0;
        w_rd_en   = 1'b0;
        w_tx_vld  = 1'b0;
        w_err     = 1'b0;
        w_addr    = r_addr;
        w_wdata   = r_wdata;
        w_fun     = r_fun;
        w_tx_data = r_tx_data;
        w_buf     = r_buf;
        w_cnt     = r_cnt;

        // Bad bytes abort a command being parsed; bytes arriving while busy are dropped.
        if (bus.RX_D_VLD && (bus.RX_ERR || !w_accepting)) begin
            w_err = 1'b1;
            if (w_accepting) w_next = S_IDLE;
        end

        case (r_state)
            S_IDLE: begin
                if (w_rx_ok) begin
                    case (w_rx_byte)
                        CMD_WR:     w_next = S_WR_ADDR;
                        CMD_RD:     w_next = S_RD_ADDR;
                        CMD_ALU_OP: w_next = S_ALU_A;
                        CMD_ALU_NO: w_next = S_ALU_FUN;
                        default:    w_err  = 1'b1;
                    endcase
                end
            end
            S_WR_ADDR: if (w_rx_ok) begin
                w_addr = w_rx_byte[ADDR_WIDTH-1:0];
                w_next = S_WR_DATA;
            end
            S_WR_DATA: if (w_rx_ok) begin
                w_wdata = w_rx_byte;
                w_wr_en = 1'b1;
                w_next  = S_IDLE;
            end
            S_RD_ADDR: if (w_rx_ok) begin
                w_addr  = w_rx_byte[ADDR_WIDTH-1:0];
                w_rd_en = 1'b1;
                w_next  = S_RD_WAIT;
            end
            S_RD_WAIT: if (bus.RdData_Valid) begin
                w_buf  = {{DATA_WIDTH{1'b0}}, bus.RdData};
                w_cnt  = 2'd1;
                w_next = S_TX_SEND;
            end
            S_ALU_A: if (w_rx_ok) begin
                w_addr  = '0;
                w_wdata = w_rx_byte;
                w_wr_en = 1'b1;
                w_next  = S_ALU_B;
            end
            S_ALU_B: if (w_rx_ok) begin
                w_addr  = ADDR_WIDTH'(1);
                w_wdata = w_rx_byte;
                w_wr_en = 1'b1;
                w_next  = S_ALU_FUN;
            end
            S_ALU_FUN: if (w_rx_ok) begin
                w_fun  = w_rx_byte[3:0];
                w_next = S_ALU_WAIT;
            end
            S_ALU_WAIT: if (bus.ALU_OUT_VLD) begin
                w_buf  = bus.ALU_OUT;
                w_cnt  = 2'd2;
                w_next = S_TX_SEND;
            end
            S_TX_SEND: if (!bus.TX_BUSY) begin
                w_tx_data = r_buf[DATA_WIDTH-1:0];
                w_tx_vld  = 1'b1;
                w_next    = S_TX_WAIT_BUSY;
            end
            S_TX_WAIT_BUSY: if (bus.TX_BUSY) w_next = S_TX_WAIT_IDLE;
            // LSB goes first, so shifting the buffer down exposes the next byte.
            S_TX_WAIT_IDLE: if (!bus.TX_BUSY) begin
                w_cnt  = 2'(r_cnt - 2'd1);
                w_buf  = r_buf >> DATA_WIDTH;
                w_next = (r_cnt > 2'd1) ? S_TX_SEND : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase

        w_alu_en = (w_next == S_ALU_WAIT);
        w_gate   = (w_next == S_ALU_WAIT) || (w_next == S_ALU_FUN);
    end

    assign bus.WrEn        = r_wr_en;
    assign bus.RdEn        = r_rd_en;
    assign bus.Address     = r_addr;
    assign bus.WrData      = r_wdata;
    assign bus.ALU_EN      = r_alu_en;
    assign bus.ALU_FUN     = r_fun;
    assign bus.CLK_GATE_EN = r_gate;
    assign bus.TX_P_DATA   = r_tx_data;
    assign bus.TX_D_VLD    = r_tx_vld;
    assign bus.cmd_err     = r_err;

endmodule

// File: doc/uart_rx_cmd_ctrl.md
Name: uart_rx_cmd_ctrl

Overview:
Command sequencer that sits between the UART receiver and the system datapath. It parses byte-framed commands from the RX path, drives the register file (write/read) and ALU (enable, function, clock gate), and returns responses to the UART transmitter through a busy-based handshake. It is the single owner of the RX byte stream and of the TX byte input.

Parameters:
DATA_WIDTH, 8, width of RX/TX byte, register data and ALU operand
ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-low reset
RX_P_DATA  input  DATA_WIDTH  received byte, valid while RX_D_VLD=1
RX_D_VLD  input  1  one-cycle pulse per received byte
RX_ERR  input  1  parity or framing error, qualified by RX_D_VLD
RdData  input  DATA_WIDTH  register-file read data
RdData_Valid  input  1  read data valid pulse
ALU_OUT  input  2*DATA_WIDTH  ALU result
ALU_OUT_VLD  input  1  ALU result valid pulse
TX_BUSY  input  1  transmitter busy
WrEn  output  1  register write strobe, one cycle
RdEn  output  1  register read strobe, one cycle
Address  output  ADDR_WIDTH  register address
WrData  output  DATA_WIDTH  register write data
ALU_EN  output  1  ALU enable
ALU_FUN  output  4  ALU function
CLK_GATE_EN  output  1  ALU clock-gate enable
TX_P_DATA  output  DATA_WIDTH  byte to transmit
TX_D_VLD  output  1  transmit request, one cycle
cmd_err  output  1  one-cycle pulse on a protocol or RX error

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-low.
- Outputs are registered. On reset, all outputs are 0 and the state is IDLE.
- Reset asserted mid-command aborts the command immediately. No partial strobe is issued after reset release.
- Commands (byte values for DATA_WIDTH=8):
  - 0xAA = RF write: cmd, addr, data.
  - 0xBB = RF read: cmd, addr.
  - 0xCC = ALU with operands: cmd, A, B, fun.
  - 0xDD = ALU without operands: cmd, fun.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_SEND, TX_WAIT_BUSY, TX_WAIT_IDLE.
- IDLE transitions on RX_D_VLD:
  - 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> ALU_A; 0xDD -> ALU_FUN.
  - Any other value -> stay in IDLE, pulse cmd_err.
- WR_ADDR: latch Address, go to WR_DATA.
- WR_DATA: on byte, the next cycle has WrEn=1 with WrData and Address stable; then IDLE.
- RD_ADDR: on byte, the next cycle has RdEn=1 with Address; then RD_WAIT.
- RD_WAIT: on RdData_Valid, capture RdData into the TX buffer, byte count 1, go to TX_SEND.
- ALU_A / ALU_B: on byte, pulse WrEn next cycle with Address=0 (A) or 1 (B) and WrData=byte.
- ALU_FUN:
  - CLK_GATE_EN=1 while in this state.
  - On byte, latch ALU_FUN=byte[3:0] and go to ALU_WAIT.
- ALU_WAIT:
  - ALU_EN=1 and CLK_GATE_EN=1 held.
  - On ALU_OUT_VLD, capture ALU_OUT, byte count 2, deassert ALU_EN and CLK_GATE_EN next cycle, go to TX_SEND.
- TX_SEND: when TX_BUSY=0, pulse TX_D_VLD for one cycle with TX_P_DATA, then go to TX_WAIT_BUSY. The first byte sent is the ALU result LSB.
- TX_WAIT_BUSY: wait for TX_BUSY=1.
- TX_WAIT_IDLE: wait for TX_BUSY=0. Then decrement the count: if bytes remain (MSB) go to TX_SEND, else IDLE.
- RX_D_VLD with RX_ERR=1 in any byte-accepting state: discard the byte, pulse cmd_err, go to IDLE. No strobes are issued.
- RX_D_VLD in RD_WAIT, ALU_WAIT or any TX_* state: drop the byte, pulse cmd_err, keep the current state.
- RdData_Valid or ALU_OUT_VLD outside its wait state: ignored.
- WrEn and RdEn are never asserted in the same cycle. TX_D_VLD is never asserted while TX_BUSY=1.

Test Plan:
- RF write: send 0xAA, 0x05, 0x3C -> one cycle with WrEn=1, Address=5, WrData=0x3C; no TX_D_VLD.
- RF read: send 0xBB, 0x05; return RdData=0x3C one cycle after RdEn -> RdEn pulses once with Address=5. TX_D_VLD pulses once with TX_P_DATA=0x3C, and only after TX_BUSY=0.
- ALU with operands: send 0xCC, 0x12, 0x34, 0x00; return ALU_OUT=0x0046 -> WrEn@addr0=0x12 and WrEn@addr1=0x34. ALU_FUN=0 and ALU_EN=1 until valid. TX sends 0x46 then 0x00, each after a TX_BUSY high-to-low cycle.
- Errors: unknown command 0x55 -> cmd_err pulse, state stays IDLE. RX_ERR=1 on the data byte of 0xAA -> cmd_err pulse, no WrEn, and a following valid 0xAA write succeeds.
- Busy and drops: hold TX_BUSY=1 during TX_SEND -> TX_D_VLD stays 0. An extra RX byte arriving during TX_WAIT_IDLE -> cmd_err pulse and the transfer completes unchanged.
- Reset: assert RST low in ALU_WAIT -> all outputs 0 asynchronously. After release, a late ALU_OUT_VLD is ignored and the FSM stays in IDLE.
